// File: rtl/pixel_accum.sv
// Pixel accumulator: sums SPP spectrum samples per pixel, converts to OUT_W-bit RGB.
// Optional macro PIXEL_ACCUM_ROUND_EN selects round-half-up conversion instead of truncation.
module pixel_accum #(
    parameter int CH_W     = 17,
    parameter int FRAC     = 16,
    parameter int LOG2_SPP = 2,
    parameter int OUT_W    = 8,
    parameter int PIX_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*CH_W-1:0]    in_spec,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*OUT_W-1:0]   out_rgb,
    output logic [PIX_W-1:0]     out_pix_idx
);

    localparam int AW  = CH_W + LOG2_SPP;
    localparam int SW  = AW + 1;
    localparam int S   = LOG2_SPP + FRAC - OUT_W;
    localparam int SPP = 1 << LOG2_SPP;
    localparam int CW  = (LOG2_SPP > 0) ? LOG2_SPP : 1;

    typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

    state_t                    state, state_nxt;
    logic [2:0][AW-1:0]        acc, sum;
    logic [2:0][CH_W-1:0]      spec;
    logic [2:0][OUT_W-1:0]     rgb_q, rgb_nxt;
    logic [CW-1:0]             cnt;
    logic                      last, acc_ok, out_hs;

    assign spec    = in_spec;
    assign out_rgb = rgb_q;
    assign last    = (cnt == CW'(SPP - 1));

    // One extra bit so the rounding constant cannot wrap before saturation.
    function automatic logic [OUT_W-1:0] conv(input logic [AW-1:0] a);
        logic [SW-1:0] t;
`ifdef PIXEL_ACCUM_ROUND_EN
        t = {1'b0, a} + (SW'(1) << (S - 1));
`else
        t = {1'b0, a};
`endif
        t = t >> S;
        if (t > SW'((1 << OUT_W) - 1))
            return '1;
        else
            return t[OUT_W-1:0];
    endfunction

    always_comb begin
        in_ready  = 1'b0;
        out_valid = (state == S_OUTPUT);
        if (!rst)
            in_ready = (state == S_ACCUM) ? !flush : out_ready;
        acc_ok = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        // In OUTPUT an accepted sample starts a fresh pixel, so it is loaded, not added.
        for (int i = 0; i < 3; i++) begin
            sum[i]     = ((state == S_OUTPUT) ? '0 : acc[i]) + AW'(spec[i]);
            rgb_nxt[i] = conv(sum[i]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACCUM:  if (!flush && acc_ok && last) state_nxt = S_OUTPUT;
            S_OUTPUT: if (out_hs) state_nxt = (acc_ok && last) ? S_OUTPUT : S_ACCUM;
            default:  state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ACCUM;
            acc         <= '0;
            cnt         <= '0;
            out_pix_idx <= '0;
            rgb_q       <= '0;
        end else begin
            state <= state_nxt;
            if (out_hs)
                out_pix_idx <= out_pix_idx + PIX_W'(1);
            if (state == S_ACCUM && flush) begin
                acc <= '0;
                cnt <= '0;
            end else if (acc_ok) begin
                if (last) begin
                    acc   <= '0;
                    cnt   <= '0;
                    rgb_q <= rgb_nxt;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end else if (out_hs) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_accum.sv
// Directed bench for pixel_accum (SPP=4, S=10, PIX_W=2 to exercise index wrap).
module tb_pixel_accum;

    localparam int CH_W = 17;
    localparam int OUT_W = 8;
    localparam int PIX_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [3*CH_W-1:0]   in_spec;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [3*OUT_W-1:0]  out_rgb;
    logic [PIX_W-1:0]    out_pix_idx;

    int n_chk = 0;
    int n_fail = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    pixel_accum #(.PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_spec(in_spec), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_rgb(out_rgb), .out_pix_idx(out_pix_idx)
    );

    typedef struct {
        logic [16:0] r, g, b;
        logic [23:0] exp_trunc;
        logic [23:0] exp_round;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a later negedge with in_valid low.
    task automatic send(input logic [3*CH_W-1:0] v);
        int n;
        in_valid = 1'b1;
        in_spec  = v;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    function automatic logic [3*CH_W-1:0] rep(input logic [16:0] x);
        return {x, x, x};
    endfunction

    // Four samples, pixel checked, then consumed with out_ready=1.
    task automatic pixel(input string name, input logic [3*CH_W-1:0] v, input logic [23:0] exp_rgb);
        for (int k = 0; k < 3; k++) send(v);
        chk({name, "_early"}, 32'(out_valid), 32'd0);
        send(v);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_rgb"}, 32'(out_rgb), 32'(exp_rgb));
        chk({name, "_idx"}, 32'(out_pix_idx), 32'(exp_idx));
        @(posedge clk); @(negedge clk); #1;
        chk({name, "_done"}, 32'(out_valid), 32'd0);
        exp_idx = (exp_idx + 1) % 4;
    endtask

    initial begin
        vecs[0] = '{17'h08000, 17'h08000, 17'h08000, 24'h808080, 24'h808080};
        vecs[1] = '{17'h10000, 17'h10000, 17'h10000, 24'hFFFFFF, 24'hFFFFFF};
        vecs[2] = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{17'h00080, 17'h00080, 17'h00080, 24'h000000, 24'h010101};
        vecs[4] = '{17'h08000, 17'h04000, 17'h00000, 24'h804000, 24'h804000};
        vecs[5] = '{17'h0C000, 17'h00100, 17'h001FF, 24'hC00101, 24'hC00102};

        rst = 1'b1; in_valid = 1'b0; in_spec = '0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_pix_idx), 32'd0);
        chk("rst_rgb", 32'(out_rgb), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Six pixels: covers conversion patterns and index wrap 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            logic [23:0] e;
`ifdef PIXEL_ACCUM_ROUND_EN
            e = vecs[i].exp_round;
`else
            e = vecs[i].exp_trunc;
`endif
            pixel($sformatf("vec%0d", i), {vecs[i].r, vecs[i].g, vecs[i].b}, e);
        end

        // Backpressure, then simultaneous output and input handshake.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(rep(17'h08000));
        for (int c = 0; c < 5; c++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_rgb", 32'(out_rgb), 32'h808080);
            @(negedge clk); #1;
        end
        chk("bp_idx", 32'(out_pix_idx), 32'(exp_idx));
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_spec = rep(17'h04000);
        #1;
        chk("bp_both_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
        exp_idx = (exp_idx + 1) % 4;
        chk("bp_released", 32'(out_valid), 32'd0);
        chk("bp_idx_inc", 32'(out_pix_idx), 32'(exp_idx));
        for (int k = 0; k < 2; k++) send(rep(17'h04000));
        chk("bp_partial", 32'(out_valid), 32'd0);
        send(rep(17'h04000));
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_rgb", 32'(out_rgb), 32'h404040);
        @(posedge clk); @(negedge clk); #1;
        exp_idx = (exp_idx + 1) % 4;

        // Flush discards a partial pixel; a sample offered with flush is refused.
        send(rep(17'h08000));
        send(rep(17'h08000));
        flush = 1'b1; in_valid = 1'b1; in_spec = rep(17'h1FFFF);
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_no_out", 32'(out_valid), 32'd0);
        chk("flush_idx", 32'(out_pix_idx), 32'(exp_idx));
        pixel("flush_pix", rep(17'h04000), 24'h404040);

        // Flush while holding a pixel is ignored.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(rep(17'h0C000));
        flush = 1'b1;
        @(negedge clk); #1;
        chk("oflush_valid", 32'(out_valid), 32'd1);
        chk("oflush_rgb", 32'(out_rgb), 32'hC0C0C0);
        flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        exp_idx = (exp_idx + 1) % 4;
        chk("oflush_idx", 32'(out_pix_idx), 32'(exp_idx));

        // Reset mid-pixel discards samples and clears the index.
        send(rep(17'h08000));
        send(rep(17'h08000));
        rst = 1'b1; in_valid = 1'b1; in_spec = rep(17'h08000);
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        exp_idx = 0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_idx", 32'(out_pix_idx), 32'd0);
        pixel("mrst_pix", rep(17'h04000), 24'h404040);

        // Reset while holding a pixel drops it.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(rep(17'h08000));
        chk("orst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        exp_idx = 0;
        chk("orst_valid", 32'(out_valid), 32'd0);
        chk("orst_idx", 32'(out_pix_idx), 32'd0);
        chk("orst_rgb", 32'(out_rgb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
